// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | fetch_queue_pkg                                                     |
// | Shared decode constants, immediate extractors and queue entry type. |
// | Rev 1.0 - initial release                                           |
// +---------------------------------------------------------------------+
package fetch_queue_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fq_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic        pred_jump;
    } iq_entry_t;

    localparam int IQ_ENTRY_W = $bits(iq_entry_t);

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | fetch_queue_fifo                                                    |
// | Circular buffer with push/pop/flush and occupancy count.            |
// | Rev 1.0 - initial release                                           |
// +---------------------------------------------------------------------+
module fetch_queue_fifo #(
    parameter int WIDTH      = 97,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    always_comb begin
        do_pop  = pop & (count_q != '0);
        // A push into a full buffer is legal only when the head leaves the same cycle.
        do_push = push & ((count_q != FULL_CNT) | do_pop);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PTR_ONE;
            if (do_pop)  head_d = head_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[tail_q] <= wdata;
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[head_q];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | fetch_queue                                                         |
// | Instruction fetch FSM with predecode-based next-PC prediction.      |
// | Option: FETCH_QUEUE_JALR_PREDICT_EN enables JALR target prediction. |
// | Rev 1.0 - initial release                                           |
// +---------------------------------------------------------------------+
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          IQ_WIDTH    = 3,
    parameter int          LOCAL_WIDTH = 10,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    output logic                   fetch_signal,
    output logic [31:0]            fetch_addr,
    input  logic                   fetch_done,
    input  logic [31:0]            fetch_instr,
    output logic [LOCAL_WIDTH-1:0] predict_addr,
    input  logic                   predict_jump,
    input  logic [31:0]            value_x1,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [31:0]            deq_instr,
    output logic [31:0]            deq_pc,
    output logic [31:0]            deq_pred_pc,
    output logic                   deq_pred_jump,
    input  logic                   clear_signal,
    input  logic [31:0]            correct_pc,
    output logic [IQ_WIDTH:0]      iq_count
);

    fq_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;

    logic        push, pop, flush;
    logic        q_empty, q_full;
    iq_entry_t   new_entry;
    iq_entry_t   head_entry;
    logic [31:0] pred_pc;
    logic        pred_jump;
    logic        hold_after;

    // Predecode of the returning instruction against the address it was fetched from.
    always_comb begin
        pred_pc    = fetch_addr_q + 32'd4;
        pred_jump  = 1'b0;
        hold_after = 1'b0;
        case (fetch_instr[6:0])
            OPC_JAL: begin
                pred_pc   = fetch_addr_q + imm_j(fetch_instr);
                pred_jump = 1'b1;
            end
            OPC_BRANCH: begin
                if (predict_jump) pred_pc = fetch_addr_q + imm_b(fetch_instr);
                pred_jump = predict_jump;
            end
            OPC_JALR: begin
`ifdef FETCH_QUEUE_JALR_PREDICT_EN
                pred_pc   = (value_x1 + imm_i(fetch_instr)) & 32'hFFFF_FFFE;
                pred_jump = 1'b1;
`else
                hold_after = 1'b1;
`endif
            end
            default: ;
        endcase
    end

`ifndef FETCH_QUEUE_JALR_PREDICT_EN
    logic unused_x1;
    assign unused_x1 = ^value_x1;
`endif

    always_comb begin
        new_entry.instr     = fetch_instr;
        new_entry.pc        = fetch_addr_q;
        new_entry.pred_pc   = pred_pc;
        new_entry.pred_jump = pred_jump;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        if (rdy_in) begin
            if (clear_signal) begin
                flush = 1'b1;
                pc_d  = correct_pc;
                // An outstanding request must still be drained, so DROP persists until it returns.
                if ((state_q == ST_WAIT || state_q == ST_DROP) && !fetch_done)
                    state_d = ST_DROP;
                else
                    state_d = ST_IDLE;
            end else begin
                pop = deq_ready & ~q_empty;
                case (state_q)
                    ST_IDLE: begin
                        if (!q_full) begin
                            state_d      = ST_WAIT;
                            fetch_addr_d = pc_q;
                        end
                    end
                    ST_WAIT: begin
                        if (fetch_done) begin
                            push    = 1'b1;
                            pc_d    = pred_pc;
                            state_d = hold_after ? ST_HOLD : ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (fetch_done) state_d = ST_IDLE;
                    end
                    ST_HOLD: ;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    fetch_queue_fifo #(
        .WIDTH      (IQ_ENTRY_W),
        .DEPTH_LOG2 (IQ_WIDTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (new_entry),
        .rdata (head_entry),
        .count (iq_count),
        .empty (q_empty),
        .full  (q_full)
    );

    assign fetch_signal  = (state_q == ST_WAIT) || (state_q == ST_DROP);
    assign fetch_addr    = fetch_addr_q;
    assign predict_addr  = fetch_addr_q[LOCAL_WIDTH+1:2];
    assign deq_valid     = ~q_empty;
    assign deq_instr     = head_entry.instr;
    assign deq_pc        = head_entry.pc;
    assign deq_pred_pc   = head_entry.pred_pc;
    assign deq_pred_jump = head_entry.pred_jump;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_fetch_queue                                                      |
// | Directed plus randomized bench with a transaction-level queue model.|
// | Rev 1.0 - initial release                                           |
// +---------------------------------------------------------------------+
module tb_fetch_queue;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, fetch_done, predict_jump, deq_ready, clear_signal;
    logic [31:0] fetch_instr, value_x1, correct_pc;
    logic        fetch_signal, deq_valid, deq_pred_jump;
    logic [31:0] fetch_addr, deq_instr, deq_pc, deq_pred_pc;
    logic [9:0]  predict_addr;
    logic [3:0]  iq_count;

    always #5 clk_in = ~clk_in;

    fetch_queue dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .fetch_signal  (fetch_signal),
        .fetch_addr    (fetch_addr),
        .fetch_done    (fetch_done),
        .fetch_instr   (fetch_instr),
        .predict_addr  (predict_addr),
        .predict_jump  (predict_jump),
        .value_x1      (value_x1),
        .deq_valid     (deq_valid),
        .deq_ready     (deq_ready),
        .deq_instr     (deq_instr),
        .deq_pc        (deq_pc),
        .deq_pred_pc   (deq_pred_pc),
        .deq_pred_jump (deq_pred_jump),
        .clear_signal  (clear_signal),
        .correct_pc    (correct_pc),
        .iq_count      (iq_count)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        bit          pj;
    } ent_t;

    // Reference: an ordered list of fetched entries plus "request outstanding / being dropped / halted".
    ent_t        mq[$];
    bit          m_busy, m_drop, m_hold;
    logic [31:0] m_pc, m_req;

    int          p_done = 100, p_deq = 0;
    bit          random_mode = 0, rand_instr = 0, force_done = 0;
    logic [31:0] fix_instr = 32'h0010_0093;
    int          saved_cnt;
    logic [31:0] saved_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_drop = 0; m_hold = 0;
        m_pc = 32'h0; m_req = 32'h0;
    endtask

    task automatic predict(input logic [31:0] ins, input logic [31:0] pc,
                           output logic [31:0] npc, output bit pj, output bit hold);
        npc = pc + 32'd4; pj = 0; hold = 0;
        if (ins[6:0] == 7'b1101111) begin
            npc = pc + 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            pj  = 1;
        end else if (ins[6:0] == 7'b1100011) begin
            if (predict_jump) npc = pc + 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            pj = predict_jump;
        end else if (ins[6:0] == 7'b1100111) begin
`ifdef FETCH_QUEUE_JALR_PREDICT_EN
            npc = (value_x1 + 32'($signed(ins[31:20]))) & 32'hFFFF_FFFE;
            pj  = 1;
`else
            hold = 1;
`endif
        end
    endtask

    task automatic model_step();
        bit          do_pop, pj, hold;
        logic [31:0] npc;
        ent_t        e;
        if (!rdy_in) return;
        if (clear_signal) begin
            mq.delete();
            m_pc   = correct_pc;
            m_hold = 0;
            if (m_busy && !fetch_done) m_drop = 1;
            else begin m_busy = 0; m_drop = 0; end
        end else begin
            do_pop = (mq.size() != 0) && deq_ready;
            if (!m_busy && !m_hold) begin
                if (mq.size() < 8) begin m_busy = 1; m_req = m_pc; end
            end else if (m_busy && fetch_done) begin
                m_busy = 0;
                if (m_drop) m_drop = 0;
                else begin
                    predict(fetch_instr, m_req, npc, pj, hold);
                    e.instr = fetch_instr; e.pc = m_req; e.pred_pc = npc; e.pj = pj;
                    mq.push_back(e);
                    m_pc   = npc;
                    m_hold = hold;
                end
            end
            if (do_pop) void'(mq.pop_front());
        end
    endtask

    task automatic check_outputs();
        chk("fetch_signal", fetch_signal, m_busy);
        if (m_busy) begin
            chk("fetch_addr", fetch_addr, m_req);
            chk("predict_addr", predict_addr, m_req[11:2]);
        end
        chk("iq_count", iq_count, mq.size());
        chk("deq_valid", deq_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("deq_instr", deq_instr, mq[0].instr);
            chk("deq_pc", deq_pc, mq[0].pc);
            chk("deq_pred_pc", deq_pred_pc, mq[0].pred_pc);
            chk("deq_pred_jump", deq_pred_jump, mq[0].pj);
        end else begin
            chk("deq_instr_empty", deq_instr, 32'h0);
            chk("deq_pc_empty", deq_pc, 32'h0);
            chk("deq_pred_pc_empty", deq_pred_pc, 32'h0);
            chk("deq_pred_jump_empty", deq_pred_jump, 32'h0);
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(4))
            0: return {r[31:7], 7'b0010011};
            1: return {r[31:7], 7'b1100011};
            2: return {r[31:7], 7'b1101111};
            3: return {r[31:7], 7'b1100111};
            default: return r;
        endcase
    endfunction

    task automatic run(input int n);
        repeat (n) begin
            if (random_mode) begin
                rdy_in       = ($urandom_range(9) != 0);
                clear_signal = ($urandom_range(19) == 0);
                correct_pc   = $urandom & 32'hFFFF_FFFC;
                predict_jump = $urandom_range(1);
                value_x1     = $urandom;
            end
            fetch_done  = force_done | (m_busy && ($urandom_range(99) < p_done));
            fetch_instr = rand_instr ? gen_instr() : fix_instr;
            deq_ready   = ($urandom_range(99) < p_deq);
            model_step();
            @(posedge clk_in);
            @(negedge clk_in);
            check_outputs();
        end
    endtask

    initial begin
        rst_in = 1; rdy_in = 0; fetch_done = 0; predict_jump = 0; deq_ready = 0;
        clear_signal = 0; fetch_instr = 0; value_x1 = 0; correct_pc = 0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk_in);
        rst_in = 0;
        rdy_in = 1;

        // Fill: one addi returned per request, nothing consumed.
        run(20);
        chk("fill_count", iq_count, 32'd8);
        chk("fill_no_fetch", fetch_signal, 32'd0);
        chk("fill_head_pc", deq_pc, 32'h0);

        // Pop from full, then simultaneous push and pop.
        p_done = 0; p_deq = 100;
        run(1);
        chk("pop_full_pc", deq_pc, 32'h4);
        p_deq = 0;
        run(1);
        saved_cnt = mq.size();
        p_done = 100; p_deq = 100;
        run(1);
        chk("push_pop_count", iq_count, saved_cnt);
        chk("push_pop_pc", deq_pc, 32'h8);
        p_done = 0;
        run(10);

        // Taken branch at 0x40 with imm -16.
        p_deq = 0; p_done = 100;
        clear_signal = 1; correct_pc = 32'h40;
        run(1);
        clear_signal = 0; fix_instr = 32'hFE00_08E3; predict_jump = 1;
        run(2);
        chk("br_pc", deq_pc, 32'h40);
        chk("br_pred_pc", deq_pred_pc, 32'h30);
        chk("br_pred_jump", deq_pred_jump, 32'd1);
        predict_jump = 0; fix_instr = 32'h0010_0093;
        run(1);
        chk("br_next_fetch", fetch_addr, 32'h30);

        // Clear during WAIT: stale response must be discarded.
        p_done = 0;
        run(1);
        chk("drop_wait", fetch_signal, 32'd1);
        clear_signal = 1; correct_pc = 32'h200;
        run(1);
        clear_signal = 0;
        run(2);
        p_done = 100;
        run(1);
        chk("drop_count", iq_count, 32'd0);
        run(1);
        chk("drop_refetch", fetch_signal, 32'd1);
        chk("drop_refetch_addr", fetch_addr, 32'h200);

        // JALR at 0x80, imm 8, x1 = 0x1001.
        clear_signal = 1; correct_pc = 32'h80;
        run(1);
        clear_signal = 0; fix_instr = 32'h0080_8067; value_x1 = 32'h1001;
        run(2);
        chk("jalr_pc", deq_pc, 32'h80);
`ifdef FETCH_QUEUE_JALR_PREDICT_EN
        chk("jalr_pred_pc", deq_pred_pc, 32'h1008);
        chk("jalr_pred_jump", deq_pred_jump, 32'd1);
        fix_instr = 32'h0010_0093;
        run(1);
        chk("jalr_next_fetch", fetch_addr, 32'h1008);
`else
        chk("jalr_pred_pc", deq_pred_pc, 32'h84);
        chk("jalr_pred_jump", deq_pred_jump, 32'd0);
        fix_instr = 32'h0010_0093;
        run(4);
        chk("jalr_hold", fetch_signal, 32'd0);
`endif
        clear_signal = 1; correct_pc = 32'h100;
        run(1);
        clear_signal = 0;

        // Pause: everything frozen while rdy_in is low.
        run(6);
        saved_cnt = mq.size(); saved_addr = m_req;
        rdy_in = 0; force_done = 1; p_deq = 100;
        run(5);
        chk("pause_count", iq_count, saved_cnt);
        chk("pause_addr", fetch_addr, saved_addr);
        rdy_in = 1; force_done = 0; p_deq = 0;

        // Asynchronous reset while a request is outstanding.
        p_done = 0;
        run(2);
        chk("rst_pre_wait", fetch_signal, 32'd1);
        #2 rst_in = 1;
        #1;
        model_reset();
        chk("rst_mid_wait", fetch_signal, 32'd0);
        check_outputs();
        @(negedge clk_in);
        rst_in = 0;

        // Randomized traffic.
        random_mode = 1; rand_instr = 1; p_done = 50; p_deq = 50;
        run(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
